line_fetch: RTL

LINE_FETCH -- requirements
Module: line_fetch

---
 rtl/line_fetch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/line_fetch.sv
// line_fetch: two-bank VGA line buffer, refilled from SDRAM two lines ahead of the beam.
// Build option LINE_FETCH_DOUBLE_EN: 320-word source lines, pixels and lines doubled on output.
module line_fetch (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        new_frame,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [24:0] base_addr,
   output logic        lb_sdram_rd,
   output logic        lb_Busy,
   output logic [24:0] lb_sdram_addr,
   input  logic        lb_sdram_Wait,
   input  logic        lb_sdram_ac,
   input  logic [15:0] lb_sdram_data,
   input  logic [9:0]  rd_x,
   output logic [15:0] rd_pixel,
   output logic        lb_overrun
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] NEXT  = 2'd2;

   localparam logic [9:0] VIS_W       = 10'd640;
   localparam logic [9:0] LAST_X      = 10'd799;
   localparam logic [9:0] LAST_TRIG_Y = 10'd477;

`ifdef LINE_FETCH_DOUBLE_EN
   localparam logic [9:0] WORDS = 10'd320;
   localparam int         AW    = 9;
`else
   localparam logic [9:0] WORDS = 10'd640;
   localparam int         AW    = 10;
`endif
   localparam int DEPTH = int'(WORDS);

   logic [1:0]    state_reg, state_next;
   logic [9:0]    word_cnt_reg, word_cnt_next;
   logic [24:0]   addr_reg, addr_next;
   logic [8:0]    line_reg, line_next;
   logic          pend_reg, pend_next;
   logic          overrun_reg, overrun_next;
   logic          rd_bank_reg, rd_ok_reg;

   logic          trig_pos, accept, last_word;
   logic [8:0]    trig_line, follow_line;
   logic [1:0]    wr_sel;
   logic [AW-1:0] wr_idx, rd_idx;

   function automatic logic [24:0] line_start(input logic [24:0] base, input logic [8:0] line);
`ifdef LINE_FETCH_DOUBLE_EN
      return base + 25'(line[8:1]) * 25'd320;
`else
      return base + 25'(line) * 25'd640;
`endif
   endfunction

   assign trig_pos    = (DrawX == LAST_X) && (DrawY <= LAST_TRIG_Y);
   assign trig_line   = DrawY[8:0] + 9'd2;
   assign follow_line = line_reg + 9'd1;

   assign lb_sdram_rd   = (state_reg == FETCH) && !lb_sdram_Wait;
   assign lb_Busy       = (state_reg != IDLE);
   assign lb_sdram_addr = addr_reg;
   assign lb_overrun    = overrun_reg;

   // An ack landing in the same cycle as new_frame belongs to the aborted line.
   assign accept    = lb_sdram_rd && lb_sdram_ac && !new_frame;
   assign last_word = (word_cnt_reg == WORDS - 10'd1);

   always_comb begin
      state_next    = state_reg;
      word_cnt_next = word_cnt_reg;
      addr_next     = addr_reg;
      line_next     = line_reg;
      pend_next     = pend_reg;
      overrun_next  = overrun_reg | (trig_pos && (state_reg != IDLE));

      if (new_frame) begin
         state_next    = FETCH;
         line_next     = 9'd0;
         pend_next     = 1'b1;
         word_cnt_next = 10'd0;
         addr_next     = line_start(base_addr, 9'd0);
      end else begin
         case (state_reg)
            IDLE: begin
               if (trig_pos) begin
                  state_next    = FETCH;
                  line_next     = trig_line;
                  pend_next     = 1'b0;
                  word_cnt_next = 10'd0;
                  addr_next     = line_start(base_addr, trig_line);
               end
            end
            FETCH: begin
               if (accept) begin
                  addr_next = addr_reg + 25'd1;
                  if (last_word) begin
                     word_cnt_next = 10'd0;
                     state_next    = pend_reg ? NEXT : IDLE;
                     pend_next     = 1'b0;
                  end else begin
                     word_cnt_next = word_cnt_reg + 10'd1;
                  end
               end
            end
            NEXT: begin
               state_next    = FETCH;
               line_next     = follow_line;
               word_cnt_next = 10'd0;
               addr_next     = line_start(base_addr, follow_line);
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         word_cnt_reg <= 10'd0;
         addr_reg     <= 25'd0;
         line_reg     <= 9'd0;
         pend_reg     <= 1'b0;
         overrun_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         word_cnt_reg <= word_cnt_next;
         addr_reg     <= addr_next;
         line_reg     <= line_next;
         pend_reg     <= pend_next;
         overrun_reg  <= overrun_next;
      end
   end

   // Bank b always holds lines with line[0] == b, so scan-out and refill never share a bank.
   assign wr_sel = accept ? (line_reg[0] ? 2'b10 : 2'b01) : 2'b00;
   assign wr_idx = word_cnt_reg[AW-1:0];
`ifdef LINE_FETCH_DOUBLE_EN
   assign rd_idx = rd_x[9:1];
`else
   assign rd_idx = rd_x;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : bank_g
         logic [15:0] mem [0:DEPTH-1];
         logic [15:0] q_reg;
         always_ff @(posedge clk) begin
            if (wr_sel[gi]) begin
               mem[wr_idx] <= lb_sdram_data;
            end
            q_reg <= mem[rd_idx];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_bank_reg <= 1'b0;
         rd_ok_reg   <= 1'b0;
      end else begin
         rd_bank_reg <= DrawY[0];
         rd_ok_reg   <= (rd_x < VIS_W);
      end
   end

   assign rd_pixel = rd_ok_reg ? (rd_bank_reg ? bank_g[1].q_reg : bank_g[0].q_reg) : 16'd0;

endmodule
